// File: rtl/power_emu_pkg.sv
// power_emu_pkg: register map, control bit positions, result width and FSM states for the power-emulator bus master
package power_emu_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_ARG    = 2'd1;
    localparam logic [1:0] ADDR_RES_LO = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_FIN_ACK = 1;
    localparam int STATUS_DONE  = 31;

    localparam int RES_W = 36;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ARG,
        S_WR_GO,
        S_WR_CLR,
        S_RD_STAT,
        S_GAP,
        S_RD_LO,
        S_RESP,
        S_WR_ACK,
        S_ACK_CLR
    } state_t;

endpackage

// File: rtl/power_emu_bus_rd.sv
// power_emu_bus_rd: issues one read strobe per request and flags when the slave's read data is valid
module power_emu_bus_rd #(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic rd,
    output logic rdata_valid
);

    logic [READ_LATENCY-1:0] sh;

    assign rd          = req & ~|sh;
    assign rdata_valid = sh[READ_LATENCY-1];

    // shift the strobe along so it pops out exactly READ_LATENCY cycles later; nonzero blocks re-issue
    always_ff @(posedge clk) begin
        if (reset)
            sh <= '0;
        else
            sh <= READ_LATENCY'({sh, rd});
    end

endmodule

// File: rtl/power_emu_master.sv
// power_emu_master: runs one job on the power-emulator slave (arg, start, poll, fetch result, ack)
module power_emu_master
    import power_emu_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int POLL_GAP     = 8,
    parameter int POLL_MAX     = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_arg,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic             res_timeout,
    output logic             busy,
    output logic             m_read,
    output logic             m_write,
    output logic [1:0]       m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata
);

    state_t      state;
    logic [31:0] arg;
    logic [3:0]  stat;
    logic [31:0] lo;
    logic        tmo;
    logic [15:0] poll_cnt;
    logic [15:0] poll_nxt;
    logic [7:0]  gap_cnt;
    logic        rd_req;
    logic        rd_valid;

    assign rd_req   = (state == S_RD_STAT) || (state == S_RD_LO);
    assign poll_nxt = poll_cnt + {15'd0, poll_cnt != 16'hFFFF};

    power_emu_bus_rd #(.READ_LATENCY(READ_LATENCY)) u_rd (
        .clk         (clk),
        .reset       (reset),
        .req         (rd_req),
        .rd          (m_read),
        .rdata_valid (rd_valid)
    );

    // job sequencing; result registers are cleared at each job start so a timeout returns zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            arg      <= '0;
            stat     <= '0;
            lo       <= '0;
            tmo      <= 1'b0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    arg      <= cmd_arg;
                    stat     <= '0;
                    lo       <= '0;
                    tmo      <= 1'b0;
                    poll_cnt <= '0;
                    state    <= S_WR_ARG;
                end
                S_WR_ARG: state <= S_WR_GO;
                S_WR_GO:  state <= S_WR_CLR;
                S_WR_CLR: state <= S_RD_STAT;
                S_RD_STAT: if (rd_valid) begin
                    poll_cnt <= poll_nxt;
                    if (m_rdata[STATUS_DONE]) begin
                        stat  <= m_rdata[3:0];
                        state <= S_RD_LO;
                    end else if (poll_nxt == 16'(POLL_MAX)) begin
                        tmo   <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                    if (gap_cnt == 8'(POLL_GAP - 1))
                        state <= S_RD_STAT;
                end
                S_RD_LO: if (rd_valid) begin
                    lo    <= m_rdata;
                    state <= S_RESP;
                end
                S_RESP:    if (res_ready) state <= S_WR_ACK;
                S_WR_ACK:  state <= S_ACK_CLR;
                S_ACK_CLR: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // handshake and bus outputs decoded from state; address and data are zero outside strobe cycles
    always_comb begin
        cmd_ready   = state == S_IDLE;
        busy        = state != S_IDLE;
        res_valid   = state == S_RESP;
        res_data    = res_valid ? {stat, lo} : '0;
        res_timeout = res_valid & tmo;
        m_write     = state inside {S_WR_ARG, S_WR_GO, S_WR_CLR, S_WR_ACK, S_ACK_CLR};
        m_addr      = m_read ? (state == S_RD_LO ? ADDR_RES_LO : ADDR_STATUS) :
                      state == S_WR_ARG ? ADDR_ARG : ADDR_CTRL;
        m_wdata     = state == S_WR_ARG ? arg :
                      state == S_WR_GO  ? 32'd1 << CTRL_START :
                      state == S_WR_ACK ? 32'd1 << CTRL_FIN_ACK : '0;
    end

endmodule

// File: tb/tb_power_emu_master.sv
// tb_power_emu_master: directed checks of the power-emulator master against a small slave model
module tb_power_emu_master;
    import power_emu_pkg::*;

    logic             clk = 0;
    logic             reset = 1;
    logic             cmd_valid = 0;
    logic             cmd_ready;
    logic [31:0]      cmd_arg = 0;
    logic             res_valid;
    logic             res_ready = 0;
    logic [RES_W-1:0] res_data;
    logic             res_timeout;
    logic             busy;
    logic             m_read;
    logic             m_write;
    logic [1:0]       m_addr;
    logic [31:0]      m_wdata;
    logic [31:0]      m_rdata = 0;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t         log_q[$];
    int          cyc = 0;
    int          sreads = 0;
    int          done_on = 1;
    logic [31:0] stat_val = 0;
    logic [31:0] lo_val = 0;
    logic        both_hi = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    power_emu_master #(.READ_LATENCY(1), .POLL_GAP(8), .POLL_MAX(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_arg     (cmd_arg),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_timeout (res_timeout),
        .busy        (busy),
        .m_read      (m_read),
        .m_write     (m_write),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata)
    );

    // slave model with registered read data; done appears on the done_on-th status read of a job
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_read || m_write) log_q.push_back('{cyc, m_write, m_addr, m_wdata});
        if (m_read && m_write) both_hi <= 1'b1;
        if (m_write && m_addr == ADDR_ARG) sreads <= 0;
        if (m_read) begin
            if (m_addr == ADDR_STATUS) sreads <= sreads + 1;
            m_rdata <= m_addr == ADDR_STATUS ?
                       ((done_on != 0 && sreads + 1 >= done_on) ? (stat_val | 32'h8000_0000) : stat_val) :
                       m_addr == ADDR_RES_LO ? lo_val : 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_ev(input string tag, input int i, input logic wr, input logic [1:0] a,
                          input logic [31:0] d, input int c);
        if (i >= log_q.size())
            chk({tag, "_missing"}, 64'(log_q.size()), 64'(i + 1));
        else
            chk(tag, {log_q[i].wr, log_q[i].addr, log_q[i].data, 16'(log_q[i].cyc)},
                     {wr, a, d, 16'(c)});
    endtask

    task automatic start_job(input logic [31:0] a, output int c0);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_arg   = a;
        cmd_valid = 1;
        c0        = cyc;
        cyc_n(1);
        cmd_valid = 0;
    endtask

    task automatic wait_res(output int t);
        int n = 0;
        while (!res_valid && n < 300) begin
            cyc_n(1);
            n++;
        end
        t = cyc;
        chk("res_wait", 64'(res_valid), 64'd1);
    endtask

    task automatic finish_job(input string tag, input int idx);
        int h = cyc;
        res_ready = 1;
        cyc_n(1);
        res_ready = 0;
        cyc_n(2);
        chk_ev({tag, "_ack"}, idx, 1'b1, ADDR_CTRL, 32'h2, h + 1);
        chk_ev({tag, "_ackclr"}, idx + 1, 1'b1, ADDR_CTRL, 32'h0, h + 2);
        chk({tag, "_idle"}, {cmd_ready, busy}, 64'b10);
    endtask

    initial begin
        int c0, c1, t, base;
        logic [RES_W-1:0] d;

        cyc_n(3);
        chk("reset_outs", {cmd_ready, busy, res_valid, res_timeout, m_read, m_write, m_addr, m_wdata},
            {1'b1, 39'd0});
        chk("reset_res", 64'(res_data), 64'd0);
        reset = 0;
        cyc_n(1);
        chk("post_reset", {cmd_ready, busy, m_read, m_write}, 64'b1000);

        // basic job with backpressure
        done_on = 1; stat_val = 32'h5; lo_val = 32'hFFFF_FFFF; base = log_q.size();
        start_job(32'hA5, c0);
        wait_res(t);
        chk("basic_lat", 64'(t - c0), 64'd8);
        chk("basic_res", 64'(res_data), 64'h5_FFFF_FFFF);
        chk("basic_tmo", 64'(res_timeout), 64'd0);
        chk("basic_nev", 64'(log_q.size() - base), 64'd5);
        chk_ev("basic_arg", base,     1'b1, ADDR_ARG,    32'hA5, c0 + 1);
        chk_ev("basic_go",  base + 1, 1'b1, ADDR_CTRL,   32'h1,  c0 + 2);
        chk_ev("basic_clr", base + 2, 1'b1, ADDR_CTRL,   32'h0,  c0 + 3);
        chk_ev("basic_rs",  base + 3, 1'b0, ADDR_STATUS, 32'h0,  c0 + 4);
        chk_ev("basic_rl",  base + 4, 1'b0, ADDR_RES_LO, 32'h0,  c0 + 6);
        d = res_data;
        for (int i = 0; i < 10; i++) begin
            cyc_n(1);
            chk("bp_hold", {res_valid, cmd_ready, busy, res_data}, {1'b1, 1'b0, 1'b1, d});
        end
        chk("bp_bus", 64'(log_q.size() - base), 64'd5);
        finish_job("basic", base + 5);

        // done on the third status poll
        done_on = 3; stat_val = 32'hA; lo_val = 32'h1234_5678; base = log_q.size();
        start_job(32'h77, c0);
        wait_res(t);
        chk("poll_lat", 64'(t - c0), 64'd28);
        chk("poll_res", 64'(res_data), 64'hA_1234_5678);
        chk("poll_nev", 64'(log_q.size() - base), 64'd7);
        chk_ev("poll_r1", base + 3, 1'b0, ADDR_STATUS, 32'h0, c0 + 4);
        chk_ev("poll_r2", base + 4, 1'b0, ADDR_STATUS, 32'h0, c0 + 14);
        chk_ev("poll_r3", base + 5, 1'b0, ADDR_STATUS, 32'h0, c0 + 24);
        chk_ev("poll_rl", base + 6, 1'b0, ADDR_RES_LO, 32'h0, c0 + 26);
        finish_job("poll", base + 7);

        // done never set: timeout after four polls
        done_on = 0; base = log_q.size();
        start_job(32'h3C, c0);
        wait_res(t);
        chk("tmo_lat", 64'(t - c0), 64'd36);
        chk("tmo_res", 64'(res_data), 64'd0);
        chk("tmo_flag", 64'(res_timeout), 64'd1);
        chk("tmo_nev", 64'(log_q.size() - base), 64'd7);
        chk_ev("tmo_r1", base + 3, 1'b0, ADDR_STATUS, 32'h0, c0 + 4);
        chk_ev("tmo_r2", base + 4, 1'b0, ADDR_STATUS, 32'h0, c0 + 14);
        chk_ev("tmo_r3", base + 5, 1'b0, ADDR_STATUS, 32'h0, c0 + 24);
        chk_ev("tmo_r4", base + 6, 1'b0, ADDR_STATUS, 32'h0, c0 + 34);
        finish_job("tmo", base + 7);

        // reset during GAP, then a clean job
        start_job(32'h11, c0);
        cyc_n(7);
        reset = 1;
        cyc_n(1);
        chk("rst_gap", {cmd_ready, busy, res_valid, m_read, m_write}, 64'b10000);
        reset = 0; base = log_q.size();
        cyc_n(1);
        chk("rst_gap_after", {cmd_ready, busy, m_read, m_write}, 64'b1000);
        chk("rst_gap_bus", 64'(log_q.size() - base), 64'd0);
        done_on = 1; stat_val = 32'h3; lo_val = 32'hCAFE_0001;
        start_job(32'h22, c0);
        wait_res(t);
        chk("rst_job_lat", 64'(t - c0), 64'd8);
        chk("rst_job_res", 64'(res_data), 64'h3_CAFE_0001);

        // reset during RESP
        reset = 1;
        cyc_n(1);
        chk("rst_resp", {cmd_ready, busy, res_valid, res_timeout, res_data}, {1'b1, 39'd0});
        reset = 0; base = log_q.size();
        cyc_n(1);
        chk("rst_resp_bus", {64'(log_q.size() - base)}, 64'd0);

        // back-to-back with cmd_valid and res_ready held high
        done_on = 1; stat_val = 32'h1; lo_val = 32'h0BAD_F00D; base = log_q.size();
        res_ready = 1; cmd_arg = 32'h55; cmd_valid = 1;
        c0 = cyc;
        chk("b2b_ready0", 64'(cmd_ready), 64'd1);
        for (int k = 0; k < 40; k++) begin
            cyc_n(1);
            if (cmd_ready) break;
        end
        chk("b2b_gap", 64'(cyc - c0), 64'd11);
        cmd_arg = 32'h66;
        c1 = cyc;
        cyc_n(1);
        cmd_valid = 0;
        chk("b2b_busy", {cmd_ready, busy}, 64'b01);
        wait_res(t);
        chk("b2b_lat", 64'(t - c1), 64'd8);
        chk("b2b_res", 64'(res_data), 64'h1_0BAD_F00D);
        cyc_n(3);
        res_ready = 0;
        chk("b2b_idle", 64'(cmd_ready), 64'd1);
        chk_ev("b2b_arg1", base,     1'b1, ADDR_ARG,  32'h55, c0 + 1);
        chk_ev("b2b_ack1", base + 5, 1'b1, ADDR_CTRL, 32'h2,  c0 + 9);
        chk_ev("b2b_clr1", base + 6, 1'b1, ADDR_CTRL, 32'h0,  c0 + 10);
        chk_ev("b2b_arg2", base + 7, 1'b1, ADDR_ARG,  32'h66, c0 + 12);

        chk("rd_wr_exclusive", 64'(both_hi), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
